// File: rtl/smm_pkg.sv
// smm_pkg: shared constants, tag type and lane adder for smm_accum.
// Define SMM_ACC_SAT_EN to make every lane add saturate instead of wrap.
package smm_pkg;

    localparam int DEF_DATAWIDTH  = 32;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int LANE_00 = 0;
    localparam int LANE_01 = 1;
    localparam int LANE_10 = 2;
    localparam int LANE_11 = 3;

`ifdef SMM_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic valid;
        logic sel;
        logic last;
    } tag_t;

    typedef enum logic {
        ST_IDLE,
        ST_OPEN
    } acc_state_e;

    // Signed add of two sign-extended lanes; caller truncates to width.
    function automatic logic [63:0] lane_add(
        input int unsigned       width,
        input logic signed [63:0] a,
        input logic signed [63:0] b
    );
        logic signed [64:0] sum;
        logic signed [64:0] lim;
        sum = 65'(a) + 65'(b);
        lim = 65'sd1 <<< (width - 1);
        if (SAT_EN) begin
            if (sum > lim - 65'sd1) begin
                sum = lim - 65'sd1;
            end else if (sum < -lim) begin
                sum = -lim;
            end
        end
        return 64'(sum);
    endfunction

endpackage

// File: rtl/smm_accum_if.sv
// smm_accum_if: issuer-side tag strobes, core result bus and
// output handshake of the Strassen tile accumulator.
interface smm_accum_if #(
    parameter int DATAWIDTH = smm_pkg::DEF_DATAWIDTH
);
    localparam int BUSWIDTH = 4 * DATAWIDTH;

    logic                load_in;
    logic                sel_in;
    logic                last_in;
    logic [BUSWIDTH-1:0] c_in;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [BUSWIDTH-1:0] out_data;
    logic                out_sel;
    logic                busy;
    logic                overflow;

    modport master (
        output load_in, sel_in, last_in, c_in, out_ready,
        input  in_ready, out_valid, out_data, out_sel, busy, overflow
    );

    modport slave (
        input  load_in, sel_in, last_in, c_in, out_ready,
        output in_ready, out_valid, out_data, out_sel, busy, overflow
    );

endinterface

// File: rtl/smm_acc_fifo.sv
// smm_acc_fifo: small synchronous FIFO with occupancy count.
// A pop on the same edge frees a slot for a push into a full FIFO.
module smm_acc_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and count advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/smm_accum.sv
// smm_accum: follows core loads through a tag pipe, sums k-tiles per lane
// and queues finished tiles. SMM_ACC_SAT_EN selects saturating lane adds.
module smm_accum
    import smm_pkg::*;
#(
    parameter int DATAWIDTH  = DEF_DATAWIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    smm_accum_if.slave  bus
);

    localparam int BUSWIDTH = 4 * DATAWIDTH;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    tag_t [LATENCY-1:0]  pipe;
    tag_t                tag_out;
    acc_state_e          state;
    logic [BUSWIDTH-1:0] acc;
    logic [BUSWIDTH-1:0] acc_sum;
    logic [BUSWIDTH-1:0] push_tile;
    logic                push;
    logic                pop;
    logic                drop;
    logic                overflow_q;
    logic                busy_c;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [BUSWIDTH:0]   fifo_rdata;
    int unsigned         pending;

    assign tag_out   = pipe[LATENCY-1];
    assign push      = tag_out.valid & tag_out.last;
    assign pop       = ~fifo_empty & bus.out_ready;
    assign drop      = push & fifo_full & ~pop;
    assign push_tile = (state == ST_IDLE) ? bus.c_in : acc_sum;

    // Tag pipe: one stage per cycle of core latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {bus.load_in, bus.sel_in, bus.last_in};
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Lane-wise sum of the open accumulator and the incoming core word.
    always_comb begin
        acc_sum = '0;
        for (int l = LANE_00; l <= LANE_11; l++) begin
            acc_sum[l*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(lane_add(
                DATAWIDTH,
                64'($signed(acc[l*DATAWIDTH +: DATAWIDTH])),
                64'($signed(bus.c_in[l*DATAWIDTH +: DATAWIDTH]))));
        end
    end

    // Group FSM: first tile loads acc, later tiles add, last closes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (tag_out.valid) begin
                unique case (state)
                    ST_IDLE: begin
                        acc   <= bus.c_in;
                        state <= tag_out.last ? ST_IDLE : ST_OPEN;
                    end
                    ST_OPEN: begin
                        acc <= acc_sum;
                        if (tag_out.last) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Credit: queued tiles plus closing tags still in the pipe.
    always_comb begin
        pending = 32'(fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            pending = pending + 32'(pipe[i].valid & pipe[i].last);
        end
    end

    // Busy while any tag is in flight or a group is open.
    always_comb begin
        busy_c = (state == ST_OPEN);
        for (int i = 0; i < LATENCY; i++) begin
            busy_c = busy_c | pipe[i].valid;
        end
    end

    smm_acc_fifo #(
        .WIDTH (BUSWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({tag_out.sel, push_tile}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.in_ready  = (pending < 32'(FIFO_DEPTH));
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_rdata[BUSWIDTH-1:0];
    assign bus.out_sel   = fifo_rdata[BUSWIDTH];
    assign bus.busy      = busy_c;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_smm_accum.sv
// tb_smm_accum: directed and random groups against a lane-sum model;
// expected tiles are queued at issue and popped by an output monitor.
module tb_smm_accum;

    localparam int DW    = 32;
    localparam int BW    = 4 * DW;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

`ifdef SMM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [BW-1:0] data;
        logic          sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_credit = 1'b0;

    exp_t          exp_q [$];
    logic [BW-1:0] sched [int];
    logic [DW-1:0] m_sum [4];
    bit            m_open = 1'b0;

    smm_accum_if #(.DATAWIDTH(DW)) bus ();

    smm_accum #(
        .DATAWIDTH  (DW),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ref_add(logic [DW-1:0] a, logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (SAT) begin
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
        end
        return DW'(s);
    endfunction

    function automatic logic [BW-1:0] rnd_tile();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(string name, logic [BW:0] act, logic [BW:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // One issuer cycle; the core result for a load is scheduled LAT edges on.
    task automatic cycle_drive(bit load, bit sel, bit last, logic [BW-1:0] tile, bit drop);
        exp_t e;
        bus.load_in = load;
        bus.sel_in  = sel;
        bus.last_in = last;
        e.data = '0;
        e.sel  = sel;
        if (load) begin
            sched[cyc + 1 + LAT] = tile;
            if (!drop) begin
                for (int l = 0; l < 4; l++) begin
                    m_sum[l] = m_open ? ref_add(m_sum[l], tile[l*DW +: DW])
                                      : tile[l*DW +: DW];
                    e.data[l*DW +: DW] = m_sum[l];
                end
                m_open = !last;
            end
        end
        @(posedge clk);
        #1;
        bus.load_in = 1'b0;
        bus.sel_in  = 1'b0;
        bus.last_in = 1'b0;
        if (load && last && !drop) exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain(string name);
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && k < 300) begin
            idle(1);
            k++;
        end
        check(name, (BW+1)'(exp_q.size() == 0 && !bus.out_valid), (BW+1)'(1));
    endtask

    // Core model: drives the scheduled result, random junk otherwise.
    initial begin
        bus.c_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sched.exists(cyc + 1)) begin
                bus.c_in = sched[cyc + 1];
                sched.delete(cyc + 1);
            end else begin
                bus.c_in = rnd_tile();
            end
        end
    end

    // Monitor: credit against outstanding groups, pops against scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (chk_credit)
                check("in_ready", (BW+1)'(bus.in_ready),
                      (BW+1)'(exp_q.size() < DEPTH));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", (BW+1)'(1), (BW+1)'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_tile", {bus.out_sel, bus.out_data}, {e.sel, e.data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] t;
        bit            ld;
        bit            ls;
        bus.load_in   = 1'b0;
        bus.sel_in    = 1'b0;
        bus.last_in   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", (BW+1)'(bus.out_valid), (BW+1)'(0));
        check("rst_in_ready",  (BW+1)'(bus.in_ready),  (BW+1)'(1));
        check("rst_busy",      (BW+1)'(bus.busy),      (BW+1)'(0));
        check("rst_overflow",  (BW+1)'(bus.overflow),  (BW+1)'(0));
        check("rst_out_bus",   {bus.out_sel, bus.out_data}, '0);
        rst = 1'b1;
        chk_credit = 1'b1;

        // Single-tile group: visible exactly LAT edges after the load.
        cycle_drive(1'b1, 1'b0, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("latency_early", (BW+1)'(bus.out_valid), (BW+1)'(0));
        end
        @(negedge clk);
        check("latency_due", (BW+1)'(bus.out_valid), (BW+1)'(1));
        @(posedge clk);
        #1;
        drain("drain_single");
        idle(2);
        check("busy_after_single", (BW+1)'(bus.busy), (BW+1)'(0));

        // Two-tile group.
        cycle_drive(1'b1, 1'b0, 1'b0, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b0);
        cycle_drive(1'b1, 1'b0, 1'b1, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);
        drain("drain_two_tile");

        // Bubbles between k-tiles, sel on the closing tile.
        cycle_drive(1'b1, 1'b0, 1'b0, {32'd7, 32'd6, 32'd5, 32'd4}, 1'b0);
        idle(3);
        cycle_drive(1'b1, 1'b1, 1'b1, {32'd100, 32'd200, 32'd300, 32'hFFFF_FFFF}, 1'b0);
        drain("drain_bubbles");

        // Lane 0 at the signed limit.
        cycle_drive(1'b1, 1'b0, 1'b0, {96'd0, 32'h7FFF_FFF0}, 1'b0);
        cycle_drive(1'b1, 1'b0, 1'b1, {96'd0, 32'h0000_0020}, 1'b0);
        drain("drain_sat");

        // Back-pressure: fill the FIFO, then force one more group.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            cycle_drive(1'b1, 1'b0, 1'b1, rnd_tile(), 1'b0);
        idle(LAT);
        @(negedge clk);
        check("full_in_ready", (BW+1)'(bus.in_ready),  (BW+1)'(0));
        check("full_valid",    (BW+1)'(bus.out_valid), (BW+1)'(1));
        check("full_no_ovf",   (BW+1)'(bus.overflow),  (BW+1)'(0));
        @(posedge clk);
        #1;
        cycle_drive(1'b1, 1'b0, 1'b1, rnd_tile(), 1'b1);
        idle(LAT);
        @(negedge clk);
        check("forced_ovf", (BW+1)'(bus.overflow), (BW+1)'(1));
        @(posedge clk);
        #1;
        drain("drain_full");
        check("ovf_sticky", (BW+1)'(bus.overflow), (BW+1)'(1));

        // Reset with a group open discards the partial sum.
        cycle_drive(1'b1, 1'b0, 1'b0, {32'd5, 32'd6, 32'd7, 32'd8}, 1'b0);
        idle(LAT);
        check("open_busy", (BW+1)'(bus.busy), (BW+1)'(1));
        #2;
        chk_credit = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_busy",     (BW+1)'(bus.busy),      (BW+1)'(0));
        check("mid_rst_overflow", (BW+1)'(bus.overflow),  (BW+1)'(0));
        check("mid_rst_in_ready", (BW+1)'(bus.in_ready),  (BW+1)'(1));
        check("mid_rst_valid",    (BW+1)'(bus.out_valid), (BW+1)'(0));
        exp_q.delete();
        m_open = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_credit = 1'b1;
        cycle_drive(1'b1, 1'b0, 1'b1, {32'd2, 32'd2, 32'd2, 32'd2}, 1'b0);
        drain("drain_after_rst");

        // Random traffic with a credit-respecting issuer.
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 9) < 6);
            ls = ($urandom_range(0, 9) < 4);
            if (ld && !bus.in_ready) ls = 1'b0;
            t = rnd_tile();
            cycle_drive(ld, 1'($urandom_range(0, 1)), ls, t, 1'b0);
        end
        bus.out_ready = 1'b1;
        if (m_open) begin
            int k;
            k = 0;
            while (!bus.in_ready && k < 100) begin
                idle(1);
                k++;
            end
            cycle_drive(1'b1, 1'b1, 1'b1, rnd_tile(), 1'b0);
        end
        drain("drain_random");
        idle(LAT);
        check("busy_end", (BW+1)'(bus.busy), (BW+1)'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/smm_accum.md
# smm_accum

Downstream companion to the 2x2 Strassen multiply core. Tracks each `load` issued to the core through the core's fixed pipeline latency and captures the corresponding `C_out` word. Sums consecutive partial-product tiles lane-by-lane to form a blocked matrix product, C_ij = Σ_k A_ik·B_kj. Completed tiles are delivered through a small output FIFO with a valid/ready handshake, and credit-style back-pressure is returned to the tile issuer.

## Interface
- `DATAWIDTH`, 32, width of one matrix element / lane
- `BUSWIDTH`, 4*DATAWIDTH, width of one 2x2 tile; lane 0 = bits [DATAWIDTH-1:0]
- `LATENCY`, 4, clock edges from the edge sampling `load_in` to the edge sampling the matching `c_in`
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `load_in`  in  1  copy of the `load` strobe driven into the multiply core
- `sel_in`  in  1  copy of the core's `sel` for that load
- `last_in`  in  1  marks the final k-tile of an accumulation group
- `c_in`  in  BUSWIDTH  multiply core `C_out`
- `in_ready`  out  1  issuer may assert `load_in` with `last_in` this cycle
- `out_valid`  out  1  FIFO head holds a completed tile
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  BUSWIDTH  summed tile, same lane order as `c_in`
- `out_sel`  out  1  `sel_in` of the group's last tile
- `busy`  out  1  any tag in flight or group open
- `overflow`  out  1  sticky; a group completed with FIFO full, tile dropped

## Operation
- Tag pipeline: LATENCY-deep shift register of {valid, sel, last}; stage 0 is loaded with {`load_in`, `sel_in`, `last_in`} every cycle.
- Accumulator FSM:
  - IDLE: a tag emerging with valid=1 writes `c_in` into acc. It moves to OPEN if last=0. If last=1, it pushes `c_in` directly to the FIFO and stays in IDLE.
  - OPEN: a tag emerging with valid=1 sets acc ← acc + `c_in` per lane. If last=1, it pushes acc + `c_in` to the FIFO and returns to IDLE.
  - A tag emerging with valid=0 leaves the state unchanged; bubbles are allowed.
- Lane arithmetic: four independent signed DATAWIDTH adds with no cross-lane carry. Without the macro, results wrap modulo 2^DATAWIDTH.
- Credit: `in_ready` = (fifo_count + in-flight tags with last=1) < FIFO_DEPTH.
- Overflow: a push while the FIFO is full drops the tile, sets `overflow`, and the FSM still returns to IDLE. `overflow` clears only on reset.
- Simultaneous push and pop with the FIFO full is legal: the pop frees the slot, no overflow occurs, and the count is unchanged.
- Reset values: all outputs 0 except `in_ready`=1. Tags, acc, FSM (IDLE) and FIFO are all cleared. Reset mid-group discards the partial sum.

## Timing
- A tile whose last load is sampled at edge e0 is pushed at edge e0+LATENCY. `out_valid` is high from that edge.
- The FIFO head is registered; `out_data`/`out_sel` are stable while `out_valid`=1 and `out_ready`=0.
- A pop occurs on an edge with `out_valid`=1 and `out_ready`=1. The next entry is visible in the following cycle.
- Throughput: one `c_in` accumulate per cycle, one pop per cycle.
- `in_ready` is combinational from registered state only. There is no combinational path from `out_ready`.

## Configuration
- `SMM_ACC_SAT_EN` defined: each lane add saturates to signed max/min of DATAWIDTH.
- `SMM_ACC_SAT_EN` undefined: each lane add wraps. No port difference.

## Structure
- Package `smm_pkg` holds:
  - default DATAWIDTH and LATENCY constants;
  - lane index constants LANE_00, LANE_01, LANE_10, LANE_11;
  - the tag typedef {valid, sel, last};
  - a per-lane add function with macro-selected saturation.
- Sub-module `smm_acc_fifo`: synchronous FIFO with count output, FIFO_DEPTH entries, width BUSWIDTH+1.

## Test plan
- Single group: `load_in`=1, `last_in`=1, `c_in`={4,3,2,1} at edge e0+4 -> `out_valid` from e0+4, `out_data`={4,3,2,1}, `busy` low afterwards.
- Two-tile group: k0 `c_in`={1,1,1,1}, k1 `c_in`={10,20,30,40} with last -> one output {11,21,31,41}.
- Back-pressure: `out_ready`=0, issue FIFO_DEPTH single-tile groups -> `in_ready` low after the 4th issue, FIFO full, `overflow`=0. Forced 5th issue -> `overflow`=1, first 4 tiles pop intact.
- Saturation: lane 0 values 0x7FFFFFF0 + 0x20 -> with `SMM_ACC_SAT_EN` 0x7FFFFFFF; without it 0x80000010.
- Reset mid-group: open group after k0, assert `rst` low -> all outputs reset immediately. Next group {2,2,2,2} last -> output {2,2,2,2} with no leftover k0 sum.
- Bubbles and sel: k0 and k1 separated by 3 idle cycles, `sel_in`=1 on last -> correct sum, `out_sel`=1.
